// File: rtl/stream_rx_pkg.sv
// Shared definitions for the layer-stream receive path.
//   - state_t       : dispatcher FSM encoding
//   - seg_id_t      : segment identifiers, also used by the DMA control block
//   - seg_advance() : next non-empty segment after a given state
package stream_rx_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WGT,
    ST_BIAS,
    ST_FEAT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_WEIGHT  = 2'd0,
    SEG_BIAS    = 2'd1,
    SEG_FEATURE = 2'd2
  } seg_id_t;

  // Segment order is fixed (weight, bias, feature); empty segments are
  // skipped so the caller lands directly on the next one holding beats.
  function automatic state_t seg_advance(input state_t from,
                                         input logic   wgt_nz,
                                         input logic   bias_nz,
                                         input logic   feat_nz);
    state_t nxt;
    nxt = ST_DONE;
    case (from)
      ST_IDLE: begin
        if (wgt_nz)       nxt = ST_WGT;
        else if (bias_nz) nxt = ST_BIAS;
        else if (feat_nz) nxt = ST_FEAT;
      end
      ST_WGT: begin
        if (bias_nz)      nxt = ST_BIAS;
        else if (feat_nz) nxt = ST_FEAT;
      end
      ST_BIAS: begin
        if (feat_nz)      nxt = ST_FEAT;
      end
      default: nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stream_rx_dispatch.sv
// AXI4-Stream slave splitting one DMA transfer per layer into weight, bias
// and feature segments, forwarding each beat with a per-segment valid strobe.
// Ports:
//   sclk, s_rst                      clock, synchronous active-high reset
//   cfg_start, cfg_*_beats           start pulse and per-segment beat counts
//   s_axis_tdata/tvalid/tlast/tready DMA stream input
//   weight_afull, feature_afull      buffer almost-full backpressure
//   stream_rx_data, stream_*_vld     registered payload and segment strobes
//   busy, done, err_len              transfer status
module stream_rx_dispatch
  import stream_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_weight_beats,
  input  logic [CNT_W-1:0]  cfg_bias_beats,
  input  logic [CNT_W-1:0]  cfg_feature_beats,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              weight_afull,
  input  logic              feature_afull,
  output logic [DATA_W-1:0] stream_rx_data,
  output logic              stream_weight_vld,
  output logic              stream_bias_vld,
  output logic              stream_feature_vld,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  state_t           state_q, state_d, last_seg;
  logic [CNT_W-1:0] wgt_cnt_q, bias_cnt_q, feat_cnt_q, beat_q, seg_cnt;
  logic             hs, last_beat, tlast_err;

  // Segment bookkeeping derived from the latched counts.
  always_comb begin
    seg_cnt = '0;
    case (state_q)
      ST_WGT:  seg_cnt = wgt_cnt_q;
      ST_BIAS: seg_cnt = bias_cnt_q;
      ST_FEAT: seg_cnt = feat_cnt_q;
      default: seg_cnt = '0;
    endcase
    last_beat = (beat_q == seg_cnt - CNT_W'(1));
    if (|feat_cnt_q)      last_seg = ST_FEAT;
    else if (|bias_cnt_q) last_seg = ST_BIAS;
    else                  last_seg = ST_WGT;
    hs = s_axis_tvalid && s_axis_tready;
    // tlast must coincide exactly with the final beat of the last non-empty
    // segment; a mismatch either way (early or missing) aborts the transfer.
    tlast_err = hs && (s_axis_tlast != (last_beat && (state_q == last_seg)));
  end

  // State register
  always_ff @(posedge sclk) begin
    if (s_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start)
          state_d = seg_advance(ST_IDLE, |cfg_weight_beats, |cfg_bias_beats,
                                |cfg_feature_beats);
      end
      ST_WGT, ST_BIAS, ST_FEAT: begin
        if (tlast_err)
          state_d = ST_DONE;
        else if (hs && last_beat)
          state_d = seg_advance(state_q, |wgt_cnt_q, |bias_cnt_q, |feat_cnt_q);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; tready is forced low during reset so a held beat is not consumed.
  always_comb begin
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_WGT: begin
        s_axis_tready = !s_rst && !weight_afull;
        busy          = 1'b1;
      end
      ST_BIAS: begin
        s_axis_tready = !s_rst;
        busy          = 1'b1;
      end
      ST_FEAT: begin
        s_axis_tready = !s_rst && !feature_afull;
        busy          = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath, counters and status
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wgt_cnt_q          <= '0;
      bias_cnt_q         <= '0;
      feat_cnt_q         <= '0;
      beat_q             <= '0;
      stream_rx_data     <= '0;
      stream_weight_vld  <= 1'b0;
      stream_bias_vld    <= 1'b0;
      stream_feature_vld <= 1'b0;
      err_len            <= 1'b0;
    end else begin
      stream_weight_vld  <= hs && (state_q == ST_WGT);
      stream_bias_vld    <= hs && (state_q == ST_BIAS);
      stream_feature_vld <= hs && (state_q == ST_FEAT);
      if (hs) stream_rx_data <= s_axis_tdata;

      if (state_q == ST_IDLE && cfg_start) begin
        wgt_cnt_q  <= cfg_weight_beats;
        bias_cnt_q <= cfg_bias_beats;
        feat_cnt_q <= cfg_feature_beats;
        err_len    <= 1'b0;
      end
      if (tlast_err) err_len <= 1'b1;

      if (state_d != state_q) beat_q <= '0;
      else if (hs)            beat_q <= beat_q + CNT_W'(1);
    end
  end

endmodule
